// File: rtl/demux_4_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready holding slot per channel.
// Optional per-channel accept counters are enabled by defining DEMUX4_COUNT_EN.
module demux_4_reg #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       control,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
`ifdef DEMUX4_COUNT_EN
   output logic [CNT_W-1:0] out_count0,
   output logic [CNT_W-1:0] out_count1,
   output logic [CNT_W-1:0] out_count2,
   output logic [CNT_W-1:0] out_count3,
`endif
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3
);

   logic [3:0]       full_q;
   logic [WIDTH-1:0] data_q [4];
   logic [3:0]       sel;
   logic             accept;

   always_comb begin
      sel      = 4'b0001 << control;
      // Selected slot is empty, or its consumer frees it on this edge.
      in_ready = !full_q[control] || out_ready[control];
      accept   = in_valid && in_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= '0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (accept && sel[i]) begin
               full_q[i] <= 1'b1;
               data_q[i] <= in_data;
            end else if (full_q[i] && out_ready[i]) begin
               full_q[i] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = full_q;
   assign out_data0 = data_q[0];
   assign out_data1 = data_q[1];
   assign out_data2 = data_q[2];
   assign out_data3 = data_q[3];

`ifdef DEMUX4_COUNT_EN
   logic [CNT_W-1:0] cnt_q [4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (accept && sel[i]) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign out_count0 = cnt_q[0];
   assign out_count1 = cnt_q[1];
   assign out_count2 = cnt_q[2];
   assign out_count3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_4_reg.sv
// Self-checking bench for demux_4_reg: table-driven vectors with a per-channel scoreboard.
// Counter checks are compiled in when DEMUX4_COUNT_EN is defined.
module tb_demux_4_reg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       control;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
   logic [WIDTH-1:0] od [4];
`ifdef DEMUX4_COUNT_EN
   logic [CNT_W-1:0] out_count0, out_count1, out_count2, out_count3;
`endif

   demux_4_reg #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .control   (control),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef DEMUX4_COUNT_EN
      .out_count0(out_count0),
      .out_count1(out_count1),
      .out_count2(out_count2),
      .out_count3(out_count3),
`endif
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3)
   );

   assign od[0] = out_data0;
   assign od[1] = out_data1;
   assign od[2] = out_data2;
   assign od[3] = out_data3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [1:0]  c;
      logic [31:0] d;
      logic [3:0]  r;
      int          exp_rdy;
   } vec_t;

   int unsigned      n_cmp = 0;
   int unsigned      n_bad = 0;
   logic [3:0]       m_full;
   logic [WIDTH-1:0] q [4][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One cycle: drive, check at negedge against the model, then advance past the edge.
   task automatic step(input logic v, input logic [1:0] c, input logic [31:0] d,
                       input logic [3:0] r, input int exp_rdy);
      logic mrdy;
      in_valid  = v;
      control   = c;
      in_data   = d;
      out_ready = r;
      @(negedge clk);
      mrdy = !m_full[c] || r[c];
      chk("in_ready_model", 32'(in_ready), 32'(mrdy));
      if (exp_rdy >= 0) chk("in_ready_vec", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_full));
      for (int i = 0; i < 4; i++) begin
         if (m_full[i]) begin
            chk($sformatf("out_data%0d", i), od[i], q[i][0]);
            if (r[i]) begin
               void'(q[i].pop_front());
               m_full[i] = 1'b0;
            end
         end
      end
      if (v && mrdy) begin
         q[c].push_back(d);
         m_full[c] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   vec_t vecs [10];

   initial begin
      vecs[0] = '{1'b1, 2'd0, 32'd150, 4'b1111, 1};
      vecs[1] = '{1'b1, 2'd1, 32'd200, 4'b1111, 1};
      vecs[2] = '{1'b1, 2'd2, 32'd250, 4'b1111, 1};
      vecs[3] = '{1'b1, 2'd3, 32'd300, 4'b1111, 1};
      vecs[4] = '{1'b0, 2'd0, 32'd0,   4'b1111, 1};
      vecs[5] = '{1'b1, 2'd2, 32'd250, 4'b1011, 1};
      vecs[6] = '{1'b1, 2'd2, 32'd999, 4'b1011, 0};
      vecs[7] = '{1'b1, 2'd0, 32'd55,  4'b1011, 1};
      vecs[8] = '{1'b1, 2'd2, 32'd999, 4'b1111, 1};
      vecs[9] = '{1'b0, 2'd2, 32'd0,   4'b1111, 1};

      m_full    = '0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      control   = 2'd0;
      out_ready = 4'b0000;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_data%0d", i), od[i], 32'd0);
      for (int c = 0; c < 4; c++) begin
         control = 2'(c);
         #1;
         chk($sformatf("rst_in_ready%0d", c), 32'(in_ready), 32'd1);
      end
`ifdef DEMUX4_COUNT_EN
      chk("rst_count0", 32'(out_count0), 32'd0);
`endif
      #7 rst = 1'b0;
      @(posedge clk);
      #1;

      // Routing and backpressure vectors.
      for (int k = 0; k < 10; k++) begin
         step(vecs[k].v, vecs[k].c, vecs[k].d, vecs[k].r, vecs[k].exp_rdy);
      end

      // Streaming 1..8 into ch1 with the consumer always ready.
      for (int k = 1; k <= 8; k++) step(1'b1, 2'd1, 32'(k), 4'b1111, 1);
      step(1'b0, 2'd1, 32'd0, 4'b1111, 1);
      step(1'b0, 2'd1, 32'd0, 4'b1111, 1);

      // Reset mid-operation: stall ch0 and ch3, then assert rst between edges.
      step(1'b1, 2'd0, 32'd77, 4'b0000, 1);
      step(1'b1, 2'd3, 32'd88, 4'b0000, 1);
      step(1'b1, 2'd0, 32'd66, 4'b0000, 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("mid_rst_data%0d", i), od[i], 32'd0);
      m_full = '0;
      for (int i = 0; i < 4; i++) q[i].delete();
      #3 rst = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         control = 2'(c);
         #0.5;
         chk($sformatf("post_rst_rdy%0d", c), 32'(in_ready), 32'd1);
      end
      @(posedge clk);
      #1;

`ifdef DEMUX4_COUNT_EN
      chk("cnt3_cleared", 32'(out_count3), 32'd0);
      for (int k = 0; k < 17; k++) step(1'b1, 2'd3, 32'(1000 + k), 4'b1111, 1);
      step(1'b0, 2'd3, 32'd0, 4'b1111, 1);
      chk("count3_wrap", 32'(out_count3), 32'd1);
      chk("count0", 32'(out_count0), 32'd0);
      chk("count1", 32'(out_count1), 32'd0);
      chk("count2", 32'(out_count2), 32'd0);
`else
      for (int k = 0; k < 17; k++) step(1'b1, 2'd3, 32'(1000 + k), 4'b1111, 1);
      step(1'b0, 2'd3, 32'd0, 4'b1111, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
